// File: rtl/tail_light_ctrl_if.sv
// Request and lamp signals between the switch conditioning logic and the
// tail-light controller.
interface tail_light_ctrl_if;
    logic       lt;
    logic       rt;
    logic       haz;
    logic [2:0] li;
    logic [2:0] ri;

    modport master (output lt, rt, haz, input  li, ri);
    modport slave  (input  lt, rt, haz, output li, ri);
endinterface

// File: rtl/tail_light_ctrl.sv
// Sequential turn-signal / hazard controller for three-lamp tail lights.
// A prescaler sets the pattern step rate; the lamps are a Moore decode of the state.
module tail_light_ctrl #(
    parameter int PRESCALE = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    tail_light_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] L1   = 3'd1;
    localparam logic [2:0] L2   = 3'd2;
    localparam logic [2:0] L3   = 3'd3;
    localparam logic [2:0] R1   = 3'd4;
    localparam logic [2:0] R2   = 3'd5;
    localparam logic [2:0] R3   = 3'd6;
    localparam logic [2:0] LR3  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic [2:0]       state_q, state_d;
    logic [2:0]       li, ri;

    // With PRESCALE=1 the counter never leaves zero, so tick is always high.
    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: default assignment first so every path drives state_d; no latch.
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (bus.haz || (bus.lt && bus.rt)) state_d = LR3;
                    else if (bus.lt)                   state_d = L1;
                    else if (bus.rt)                   state_d = R1;
                    else                               state_d = IDLE;
                end
                L1:      state_d = bus.haz ? LR3 : L2;
                L2:      state_d = bus.haz ? LR3 : L3;
                L3:      state_d = IDLE;
                R1:      state_d = bus.haz ? LR3 : R2;
                R2:      state_d = bus.haz ? LR3 : R3;
                R3:      state_d = IDLE;
                LR3:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from their pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        li = 3'b000;
        ri = 3'b000;
        case (state_q)
            L1:      li = 3'b001;
            L2:      li = 3'b011;
            L3:      li = 3'b111;
            R1:      ri = 3'b001;
            R2:      ri = 3'b011;
            R3:      ri = 3'b111;
            LR3: begin
                li = 3'b111;
                ri = 3'b111;
            end
            default: begin
                li = 3'b000;
                ri = 3'b000;
            end
        endcase
    end

    assign bus.li = li;
    assign bus.ri = ri;

endmodule

// File: tb/tb_tail_light_ctrl.sv
// Self-checking bench: PRESCALE=1 and PRESCALE=4 controllers driven in parallel
// and compared every clock against a lamp-level reference model.
module tb_tail_light_ctrl;

    logic clk;
    logic rst;

    tail_light_ctrl_if bus1 ();
    tail_light_ctrl_if bus4 ();

    tail_light_ctrl #(.PRESCALE(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    tail_light_ctrl #(.PRESCALE(4), .CNT_W(16)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: lamp patterns and clocks elapsed since reset release.
    int         pre[2]   = '{1, 4};
    int         since[2] = '{0, 0};
    logic [2:0] m_li[2]  = '{3'd0, 3'd0};
    logic [2:0] m_ri[2]  = '{3'd0, 3'd0};

    logic [2:0] lseq[4] = '{3'b001, 3'b011, 3'b111, 3'b000};

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Next lamp pattern from the current one: a lit side keeps filling outward
    // until all three are lit, then goes dark; hazard aborts a partial fill.
    function automatic void next_lamps(input logic [2:0] li, input logic [2:0] ri,
                                       input logic lt, input logic rt, input logic haz,
                                       output logic [2:0] nli, output logic [2:0] nri);
        nli = 3'b000;
        nri = 3'b000;
        if (li == 3'b111 && ri == 3'b111) begin
            nli = 3'b000;
            nri = 3'b000;
        end else if (li != 3'b000) begin
            if (li == 3'b111) nli = 3'b000;
            else if (haz) begin
                nli = 3'b111;
                nri = 3'b111;
            end else nli = {li[1:0], 1'b1};
        end else if (ri != 3'b000) begin
            if (ri == 3'b111) nri = 3'b000;
            else if (haz) begin
                nli = 3'b111;
                nri = 3'b111;
            end else nri = {ri[1:0], 1'b1};
        end else if (haz || (lt && rt)) begin
            nli = 3'b111;
            nri = 3'b111;
        end else if (lt) nli = 3'b001;
        else if (rt)     nri = 3'b001;
    endfunction

    task automatic set_in(input logic r, input logic lt, input logic rt, input logic haz);
        rst      = r;
        bus1.lt  = lt;
        bus1.rt  = rt;
        bus1.haz = haz;
        bus4.lt  = lt;
        bus4.rt  = rt;
        bus4.haz = haz;
    endtask

    // One clock: advance the model from pre-edge inputs, then compare both DUTs.
    task automatic cycle();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                since[k] = 0;
                m_li[k]  = 3'b000;
                m_ri[k]  = 3'b000;
            end else begin
                since[k]++;
                if (since[k] % pre[k] == 0)
                    next_lamps(m_li[k], m_ri[k], bus1.lt, bus1.rt, bus1.haz, m_li[k], m_ri[k]);
            end
        end
        @(posedge clk);
        #1;
        check("p1_li", bus1.li, m_li[0]);
        check("p1_ri", bus1.ri, m_ri[0]);
        check("p4_li", bus4.li, m_li[1]);
        check("p4_ri", bus4.ri, m_ri[1]);
    endtask

    initial begin
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held with lt asserted: lamps dark.
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("rst_li", bus1.li, 3'b000);
            check("rst_ri", bus1.ri, 3'b000);
        end

        // Release with lt held: 001,011,111,000,001.
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("lt_seq", bus1.li, lseq[i % 4]);
            check("lt_ri0", bus1.ri, 3'b000);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        check("lt_done", bus1.li, 3'b000);

        // Right turn held from IDLE.
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("rt_seq", bus1.ri, lseq[i % 4]);
            check("rt_li0", bus1.li, 3'b000);
        end

        // Hazard from IDLE alternates all-on / all-off, then stays idle.
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("haz_li", bus1.li, (i % 2 == 0) ? 3'b111 : 3'b000);
            check("haz_ri", bus1.ri, (i % 2 == 0) ? 3'b111 : 3'b000);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("haz_off", bus1.li | bus1.ri, 3'b000);
        end

        // One-clock lt pulse completes the whole sequence.
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        check("pulse0", bus1.li, 3'b001);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            cycle();
            check("pulse_seq", bus1.li, lseq[i]);
        end

        // Hazard while in L2 aborts straight to all-on.
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("abort_l2", bus1.li, 3'b011);
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        check("abort_li", bus1.li, 3'b111);
        check("abort_ri", bus1.ri, 3'b111);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cycle();

        // lt&rt together, and haz with lt, both give all-on.
        set_in(1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        check("ltrt_li", bus1.li, 3'b111);
        check("ltrt_ri", bus1.ri, 3'b111);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        check("hazlt_li", bus1.li, 3'b111);
        check("hazlt_ri", bus1.ri, 3'b111);

        // PRESCALE=4 with lt held from a fresh reset: each value lasts 4 clocks.
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            cycle();
            check("p4_seq", bus4.li, (i < 3) ? 3'b000 : lseq[((i - 3) / 4) % 4]);
        end

        // Reset mid-step: immediate dark, counter restarts from zero.
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        check("p4_rst", bus4.li, 3'b000);
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("p4_restart_wait", bus4.li, 3'b000);
        end
        cycle();
        check("p4_restart_tick", bus4.li, 3'b001);

        // Randomized traffic, occasional reset.
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 49) == 0,
                   $urandom_range(0, 2) == 0,
                   $urandom_range(0, 2) == 0,
                   $urandom_range(0, 7) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
